forward_pass: RTL and testbench

//  Forward raster-scan denoise stage; first stage of the forward/backward/threshold/convolution chain.

---
 rtl/den_pkg.sv | 24 ++
 rtl/forward_pass_if.sv | 16 +
 rtl/fwd_line_buf.sv | 30 +++
 rtl/forward_pass.sv | 115 +++++++++++
 tb/tb_forward_pass.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/den_pkg.sv
// Shared constants, FSM state type and the smoothing kernel for the denoise chain.
package den_pkg;
  localparam int unsigned IMG_W = 64;
  localparam int unsigned IMG_H = 64;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned N_PIC = 6;
  localparam int unsigned N_PIX = IMG_W * IMG_H;
  localparam int unsigned AW    = $clog2(N_PIX);
  localparam int unsigned XW    = $clog2(IMG_W);
  localparam int unsigned YW    = $clog2(IMG_H);

  localparam logic [2:0] RAM_SEL_NONE = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fwd_state_t;

  // (2*i + l + u) >> 2; the 4-term sum of PIX_W values never exceeds PIX_W+2 bits
  function automatic logic [PIX_W-1:0] fwd_filter(input logic [PIX_W-1:0] i,
                                                  input logic [PIX_W-1:0] l,
                                                  input logic [PIX_W-1:0] u);
    logic [PIX_W+1:0] sum;
    sum = {1'b0, i, 1'b0} + {2'b00, l} + {2'b00, u};
    return sum[PIX_W+1:2];
  endfunction
endpackage

// File: rtl/forward_pass_if.sv
// Image-memory read bus and ping-pong RAM write bus of the forward stage.
interface forward_pass_if;
  import den_pkg::*;

  logic             img_rd;
  logic [AW+2:0]    img_addr;
  logic [PIX_W-1:0] img_data;
  logic [2:0]       ram_wen;
  logic [AW-1:0]    ram_addr;
  logic [PIX_W-1:0] ram_wdata;

  modport master (output img_rd, img_addr, ram_wen, ram_addr, ram_wdata,
                  input  img_data);
  modport slave  (input  img_rd, img_addr, ram_wen, ram_addr, ram_wdata,
                  output img_data);
endinterface

// File: rtl/fwd_line_buf.sv
// One row of previous-row filter outputs; slot valid bits mark data written this picture.
module fwd_line_buf
  import den_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [XW-1:0]    rd_x,
  output logic [PIX_W-1:0] rd_data,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [XW-1:0]    wr_x,
  input  logic [PIX_W-1:0] wr_data
);
  logic [PIX_W-1:0] mem [IMG_W];
  logic [IMG_W-1:0] vld;

  assign rd_data  = mem[rd_x];
  assign rd_valid = vld[rd_x];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      vld <= '0;
    else if (clr)   vld <= '0;
    else if (wr_en) vld[wr_x] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_x] <= wr_data;
  end
endmodule

// File: rtl/forward_pass.sv
// Forward raster-scan causal smoother: image memory -> selected ping-pong bank.
// Optional build macro FWD_CYCLE_CNT_EN adds the run_cycles counter output.
module forward_pass
  import den_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           all_rst,
  input  logic           forward_valid,
  input  logic [2:0]     f_RAM_sel,
  forward_pass_if.master bus,
  output logic           forward_done
`ifdef FWD_CYCLE_CNT_EN
  ,
  output logic [AW+1:0]  run_cycles
`endif
);
  fwd_state_t       state;
  logic [2:0]       pic_idx;
  logic [2:0]       sel_q;
  logic [XW-1:0]    rx, wx;
  logic [YW-1:0]    ry, wy;
  logic             wr_vld;
  logic [PIX_W-1:0] l_q;

  logic             start, rd, last_rd, wr_fire;
  logic [PIX_W-1:0] u_buf, l_val, u_val, o_pix;
  logic             u_valid;

  assign start   = (state == IDLE) && forward_valid && !all_rst;
  assign rd      = (state == RUN) && !all_rst;
  assign last_rd = (rx == XW'(IMG_W - 1)) && (ry == YW'(IMG_H - 1));
  assign wr_fire = wr_vld && !all_rst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pic_idx <= '0;
      sel_q   <= '0;
      rx      <= '0;
      ry      <= '0;
      wx      <= '0;
      wy      <= '0;
      wr_vld  <= 1'b0;
      l_q     <= '0;
    end else if (all_rst) begin
      state  <= IDLE;
      rx     <= '0;
      ry     <= '0;
      wr_vld <= 1'b0;
      l_q    <= '0;
    end else begin
      wr_vld <= rd;
      wx     <= rx;
      wy     <= ry;
      if (wr_fire) l_q <= o_pix;
      case (state)
        IDLE: if (forward_valid) begin
          state <= RUN;
          sel_q <= f_RAM_sel;
          rx    <= '0;
          ry    <= '0;
        end
        RUN: begin
          if (last_rd) state <= DRAIN;
          rx <= rx + 1'b1;
          if (rx == XW'(IMG_W - 1)) ry <= ry + 1'b1;
        end
        DRAIN: begin
          state   <= DONE;
          pic_idx <= (pic_idx == 3'(N_PIC - 1)) ? '0 : pic_idx + 1'b1;
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  fwd_line_buf u_line_buf (
    .clk      (clk),
    .reset    (reset),
    .clr      (all_rst | start),
    .rd_x     (wx),
    .rd_data  (u_buf),
    .rd_valid (u_valid),
    .wr_en    (wr_fire),
    .wr_x     (wx),
    .wr_data  (o_pix)
  );

  // Borders substitute the current input for the missing neighbour
  always_comb begin
    l_val = (wx == '0) ? bus.img_data : l_q;
    u_val = ((wy != '0) && u_valid) ? u_buf : bus.img_data;
    o_pix = fwd_filter(bus.img_data, l_val, u_val);
  end

  assign bus.img_rd    = rd;
  assign bus.img_addr  = rd ? {pic_idx, ry, rx} : '0;
  assign bus.ram_wen   = (wr_fire && (sel_q < 3'd3)) ? (3'b001 << sel_q[1:0]) : 3'b000;
  assign bus.ram_addr  = wr_vld ? {wy, wx} : '0;
  assign bus.ram_wdata = wr_vld ? o_pix : '0;
  assign forward_done  = (state == DONE);

`ifdef FWD_CYCLE_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      run_cycles <= '0;
    else if (start)
      run_cycles <= '0;
    else if (!all_rst && ((state == RUN) || (state == DRAIN)))
      run_cycles <= run_cycles + 1'b1;
  end
`endif
endmodule

// File: tb/tb_forward_pass.sv
// Scoreboard bench for forward_pass: expected reads/writes queued per picture, checked by a monitor.
module tb_forward_pass;
  import den_pkg::*;

  localparam int N = int'(N_PIX);

  typedef struct {
    int          addr;
    int          data;
    logic [2:0]  wen;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       all_rst;
  logic       forward_valid;
  logic [2:0] f_RAM_sel;
  logic       forward_done;
`ifdef FWD_CYCLE_CNT_EN
  logic [AW+1:0] run_cycles;
`endif

  forward_pass_if bus ();

  forward_pass dut (
    .clk           (clk),
    .reset         (reset),
    .all_rst       (all_rst),
    .forward_valid (forward_valid),
    .f_RAM_sel     (f_RAM_sel),
    .bus           (bus.master),
    .forward_done  (forward_done)
`ifdef FWD_CYCLE_CNT_EN
    ,
    .run_cycles    (run_cycles)
`endif
  );

  always #5 clk = ~clk;

  logic [PIX_W-1:0] mem [N_PIC*N];
  logic [PIX_W-1:0] cap [N];

  always @(posedge clk or posedge reset) begin
    if (reset)           bus.img_data <= '0;
    else if (bus.img_rd) bus.img_data <= mem[bus.img_addr];
  end

  int   rdq[$];
  wr_t  wrq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_rd_cyc = 0;
  int   wcount = 0;
  logic done_q = 1'b0;
  int   exp_pic = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every read and write the DUT presents must match the head of its queue
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.img_rd) begin
        last_rd_cyc = cyc;
        if (rdq.size() == 0) chk("unexpected_rd", int'(bus.img_addr), -1);
        else                 chk("rd_addr", int'(bus.img_addr), rdq.pop_front());
      end
      if (bus.ram_wen != 3'b000) begin
        wcount++;
        cap[bus.ram_addr] = bus.ram_wdata;
        if (wrq.size() == 0) chk("unexpected_wr", int'(bus.ram_addr), -1);
        else begin
          wr_t w;
          w = wrq.pop_front();
          chk("wr_addr", int'(bus.ram_addr), w.addr);
          chk("wr_data", int'(bus.ram_wdata), w.data);
          chk("wr_wen", int'(bus.ram_wen), int'(w.wen));
        end
      end
      if (forward_done && !done_q) chk("done_latency", cyc - last_rd_cyc, 2);
      done_q = forward_done;
    end
  end

  function automatic int pattern(input int kind, input int pic, input int x, input int y);
    case (kind)
      0:       return 100;
      1:       return x;
      2:       return (x == 0 && y == 0) ? 255 : 0;
      default: return (x * 37 + y * 11 + pic * 5 + x * y) % 256;
    endcase
  endfunction

  task automatic fill_mem(input int pic, input int kind);
    for (int idx = 0; idx < N; idx++)
      mem[pic*N + idx] = PIX_W'(pattern(kind, pic, idx % int'(IMG_W), idx / int'(IMG_W)));
  endtask

  // Reference smoother straight from the recurrence; queues nrd reads and nwr writes
  task automatic expect_pic(input int pic, input int sel, input int nrd, input int nwr);
    int o[N];
    int i, l, u, x, y;
    for (int idx = 0; idx < N; idx++) begin
      x = idx % int'(IMG_W);
      y = idx / int'(IMG_W);
      i = int'(mem[pic*N + idx]);
      l = (x == 0) ? i : o[idx-1];
      u = (y == 0) ? i : o[idx-int'(IMG_W)];
      o[idx] = (2*i + l + u) / 4;
    end
    for (int k = 0; k < nrd; k++) rdq.push_back(pic*N + k);
    if (sel < 3) begin
      for (int k = 0; k < nwr; k++) begin
        wr_t w;
        w.addr = k;
        w.data = o[k];
        w.wen  = 3'(1 << sel);
        wrq.push_back(w);
      end
    end
  endtask

  // Leaves the bench in the first RUN cycle (pixel 0 being read)
  task automatic start_pic(input int sel, input bit with_rst);
    @(posedge clk); #1;
    f_RAM_sel = 3'(sel);
    forward_valid = 1'b1;
    if (with_rst) begin
      all_rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_beats_valid", int'(bus.img_rd), 0);
      all_rst = 1'b0;
    end
    @(posedge clk); #1;
    forward_valid = 1'b0;
    f_RAM_sel = 3'(sel) ^ 3'b001;
  endtask

  task automatic clear_stage();
    @(posedge clk); #1;
    all_rst = 1'b1;
    @(posedge clk); #1;
    all_rst = 1'b0;
    @(negedge clk);
    chk("done_cleared", int'(forward_done), 0);
  endtask

  task automatic run_pic(input int sel, input int kind, input bit with_rst, input bit refill);
    if (refill) fill_mem(exp_pic, kind);
    expect_pic(exp_pic, sel, N, N);
    wcount = 0;
    start_pic(sel, with_rst);
    for (int k = 0; k < N + 20; k++) begin
      @(negedge clk);
      if (forward_done) break;
    end
    chk("done_seen", int'(forward_done), 1);
    repeat (3) @(negedge clk);
    chk("done_held", int'(forward_done), 1);
    chk("write_count", wcount, (sel < 3) ? N : 0);
    chk("rdq_drained", rdq.size(), 0);
    chk("wrq_drained", wrq.size(), 0);
`ifdef FWD_CYCLE_CNT_EN
    chk("run_cycles", int'(run_cycles), N + 1);
`endif
    clear_stage();
    exp_pic = (exp_pic + 1) % int'(N_PIC);
  endtask

  initial begin
    reset = 1'b1;
    all_rst = 1'b0;
    forward_valid = 1'b0;
    f_RAM_sel = 3'd0;
    for (int k = 0; k < N_PIC*N; k++) mem[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_img_rd", int'(bus.img_rd), 0);
    chk("rst_img_addr", int'(bus.img_addr), 0);
    chk("rst_ram_wen", int'(bus.ram_wen), 0);
    chk("rst_ram_wdata", int'(bus.ram_wdata), 0);
    chk("rst_done", int'(forward_done), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_rd", int'(bus.img_rd), 0);

    // constant image
    run_pic(0, 0, 1'b0, 1'b1);
    chk("const_first", int'(cap[0]), 100);
    chk("const_last", int'(cap[N-1]), 100);

    // ramp i = x
    run_pic(1, 1, 1'b0, 1'b1);
    chk("ramp_o00", int'(cap[0]), 0);
    chk("ramp_o10", int'(cap[1]), 0);
    chk("ramp_o20", int'(cap[2]), 1);
    chk("ramp_o30", int'(cap[3]), 2);

    // single bright pixel at the origin
    run_pic(2, 2, 1'b0, 1'b1);
    chk("imp_o00", int'(cap[0]), 255);
    chk("imp_o10", int'(cap[1]), 63);
    chk("imp_o01", int'(cap[IMG_W]), 63);
    chk("imp_o11", int'(cap[IMG_W+1]), 31);

    // abort while pixel 10 is due: reads 0..9, writes 0..8 only
    fill_mem(exp_pic, 3);
    expect_pic(exp_pic, 1, 10, 9);
    start_pic(1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    all_rst = 1'b1;
    @(posedge clk); #1;
    all_rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_done_low", int'(forward_done), 0);
    chk("abort_rdq", rdq.size(), 0);
    chk("abort_wrq", wrq.size(), 0);
    run_pic(1, 3, 1'b1, 1'b0);

    // no bank selected
    run_pic(int'(RAM_SEL_NONE), 3, 1'b0, 1'b1);

    // six back-to-back pictures, pic_idx wraps through 0
    for (int p = 0; p < 6; p++) run_pic(p % 3, 3, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
